// File: rtl/mul_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_arb_ctrl
// Brief    : Two-requester round-robin arbiter and multicycle sequencer for the
//            shared 32x32 RV32M multiplier array (MUL/MULH/MULHSU/MULHU).
// Revision : 1.0  initial release
// ============================================================================
module mul_arb_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    output logic        mul_signed,
    input  logic [67:0] mul_result,
    output logic        busy
);

    localparam int                 c_cnt_w    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MUL_CYCLES - 1);

    localparam logic [1:0] c_op_mul    = 2'b00;
    localparam logic [1:0] c_op_mulh   = 2'b01;
    localparam logic [1:0] c_op_mulhsu = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_last;
    logic [1:0]         r_op;
    logic [31:0]        r_corr;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_grant;
    logic               w_accept;
    logic [1:0]         w_op;
    logic [31:0]        w_a;
    logic [31:0]        w_b;
    logic [31:0]        w_result;
    logic               w_unused;

    // Only the low 64 product bits carry information for 32x32 operands.
    assign w_unused = ^mul_result[67:64];

    always_comb begin
        w_grant = 1'b0;
        case (req_valid)
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~r_last;
            default: w_grant = 1'b0;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (!rst_n && (r_state == S_IDLE) && !flush) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_accept = |(req_valid & req_ready);
    assign w_op     = w_grant ? req1_op : req0_op;
    assign w_a      = w_grant ? req1_a  : req0_a;
    assign w_b      = w_grant ? req1_b  : req0_b;

    // The array runs MULHSU as signed x signed; adding rs1 to the high word
    // whenever rs2[31] is set restores the unsigned interpretation of rs2.
    always_comb begin
        w_result = mul_result[63:32];
        case (r_op)
            c_op_mul:    w_result = mul_result[31:0];
            c_op_mulhsu: w_result = mul_result[63:32] + r_corr;
            default:     w_result = mul_result[63:32];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= S_IDLE;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            mul_x      <= '0;
            mul_y      <= '0;
            mul_signed <= 1'b0;
            busy       <= 1'b0;
            r_cnt      <= '0;
            r_last     <= 1'b1;
            r_op       <= c_op_mul;
            r_corr     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        mul_x      <= w_a;
                        mul_y      <= w_b;
                        mul_signed <= (w_op == c_op_mulh) || (w_op == c_op_mulhsu);
                        r_op       <= w_op;
                        r_corr     <= ((w_op == c_op_mulhsu) && w_b[31]) ? w_a : 32'd0;
                        rsp_id     <= w_grant;
                        r_last     <= w_grant;
                        r_cnt      <= '0;
                        busy       <= 1'b1;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == c_cnt_last) begin
                        rsp_data  <= w_result;
                        rsp_valid <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    // A flush coinciding with rsp_ready drops the response; both exit to IDLE.
                    if (flush || rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_arb_ctrl.sv
`default_nettype none
// Testbench for mul_arb_ctrl: directed RV32M vectors, arbitration, backpressure,
// flush and reset cases, and randomized traffic against a scoreboard model.
module tb_mul_arb_ctrl;

    localparam int MUL_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [1:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic        mul_signed;
    logic [67:0] mul_result;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit m_last;

    mul_arb_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .mul_x(mul_x), .mul_y(mul_y), .mul_signed(mul_signed), .mul_result(mul_result),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural Booth/Wallace array: sign-extended 68-bit product.
    logic signed [67:0] arr_sx, arr_sy, arr_sp;
    logic        [67:0] arr_up;
    assign arr_sx     = {{36{mul_x[31]}}, mul_x};
    assign arr_sy     = {{36{mul_y[31]}}, mul_y};
    assign arr_sp     = arr_sx * arr_sy;
    assign arr_up     = {36'd0, mul_x} * {36'd0, mul_y};
    assign mul_result = mul_signed ? arr_sp : arr_up;

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'd1:    p = sa * sb;
            2'd2:    p = sa * longint'(ub);
            default: p = ua * ub;
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_reset();
        rst_n     = 1'b1;
        req_valid = 2'b00;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b0;
        m_last = 1'b1;
        #1;
    endtask

    task automatic issue(input logic id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int acc_cyc, output bit ok);
        bit was_ready;
        if (id) begin req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_op = op; req0_a = a; req0_b = b; end
        req_valid[id] = 1'b1;
        #1;
        ok = 1'b0;
        acc_cyc = cyc;
        for (int k = 0; k < 40; k++) begin
            was_ready = req_ready[id];
            @(posedge clk);
            #1;
            if (was_ready) begin ok = 1'b1; acc_cyc = cyc; break; end
        end
        req_valid[id] = 1'b0;
        #1;
    endtask

    task automatic wait_rsp(output int rsp_cyc, output bit ok);
        ok = 1'b0;
        rsp_cyc = cyc;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid) begin ok = 1'b1; rsp_cyc = cyc; break; end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req_valid = 2'b11; flush = 1'b0; rsp_ready = 1'b0;
        req0_op = 2'd0; req0_a = 32'd5; req0_b = 32'd6;
        req1_op = 2'd0; req1_a = 32'd7; req1_b = 32'd8;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b, expected 00", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b, expected 0", rsp_valid); end
        n_tests++; if ({rsp_id, rsp_data} !== 33'd0) begin n_fail++; $display("FAIL reset_rsp: got %h, expected 0", {rsp_id, rsp_data}); end
        n_tests++; if ({mul_signed, mul_x, mul_y} !== 65'd0) begin n_fail++; $display("FAIL reset_mul_regs: got %h, expected 0", {mul_signed, mul_x, mul_y}); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL reset_first_grant: got %b, expected 01", req_ready); end
        req_valid = 2'b00;
        m_last = 1'b1;
        #1;
    endtask

    task automatic test_directed();
        logic [1:0]  d_op [5] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2};
        logic        d_id [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] d_a  [5] = '{32'h0000_0007, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] d_b  [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
        logic [31:0] d_exp[5] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'h0};
        int acc_c, rsp_c;
        bit ok;
        d_exp[4] = ref_result(d_op[4], d_a[4], d_b[4]);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(d_id[i], d_op[i], d_a[i], d_b[i], acc_c, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL dir_accept[%0d]: got no accept, expected accept", i); end
            n_tests++;
            if ({mul_signed, mul_x, mul_y} !== {(d_op[i] == 2'd1 || d_op[i] == 2'd2), d_a[i], d_b[i]}) begin
                n_fail++; $display("FAIL dir_array_in[%0d]: got %h, expected %h", i, {mul_signed, mul_x, mul_y},
                                   {(d_op[i] == 2'd1 || d_op[i] == 2'd2), d_a[i], d_b[i]});
            end
            wait_rsp(rsp_c, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL dir_rsp_timeout[%0d]: got none, expected rsp_valid", i); end
            n_tests++; if (rsp_c - acc_c != MUL_CYCLES) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d, expected %0d", i, rsp_c - acc_c, MUL_CYCLES); end
            n_tests++; if (rsp_id !== d_id[i]) begin n_fail++; $display("FAIL dir_rsp_id[%0d]: got %b, expected %b", i, rsp_id, d_id[i]); end
            n_tests++; if (rsp_data !== d_exp[i]) begin n_fail++; $display("FAIL dir_rsp_data[%0d]: got %h, expected %h", i, rsp_data, d_exp[i]); end
            @(posedge clk); #1;
            n_tests++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL dir_release[%0d]: got %b, expected 00", i, {rsp_valid, busy}); end
        end
    endtask

    task automatic test_back_to_back();
        int n_acc = 0;
        int last_acc = 0;
        do_reset();
        req0_op = 2'd0; req0_a = $urandom; req0_b = $urandom;
        req1_op = 2'd3; req1_a = $urandom; req1_b = $urandom;
        req_valid = 2'b11;
        #1;
        for (int c = 0; c < 60 && n_acc < 4; c++) begin
            if ((req_ready & req_valid) != 2'b00) begin
                n_tests++;
                if (req_ready !== ((n_acc % 2 == 1) ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL bb_grant[%0d]: got %b, expected %b", n_acc, req_ready, (n_acc % 2 == 1) ? 2'b10 : 2'b01);
                end
                if (n_acc > 0) begin
                    n_tests++;
                    if (cyc + 1 - last_acc != MUL_CYCLES + 2) begin
                        n_fail++; $display("FAIL bb_spacing[%0d]: got %0d, expected %0d", n_acc, cyc + 1 - last_acc, MUL_CYCLES + 2);
                    end
                end
                last_acc = cyc + 1;
                n_acc++;
            end
            @(posedge clk); #1;
        end
        n_tests++; if (n_acc != 4) begin n_fail++; $display("FAIL bb_count: got %0d, expected 4", n_acc); end
        req_valid = 2'b00;
        repeat (MUL_CYCLES + 3) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int acc_c, rsp_c;
        bit ok;
        logic [31:0] a, b, exp_d;
        a = rand_operand(); b = rand_operand();
        exp_d = ref_result(2'd2, a, b);
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        issue(1'b1, 2'd2, a, b, acc_c, ok);
        wait_rsp(rsp_c, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_rsp_timeout: got none, expected rsp_valid"); end
        req_valid = 2'b11;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({rsp_valid, rsp_id, rsp_data, req_ready, busy} !== {1'b1, 1'b1, exp_d, 2'b00, 1'b1}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got %h, expected %h", i, {rsp_valid, rsp_id, rsp_data, req_ready, busy},
                                   {1'b1, 1'b1, exp_d, 2'b00, 1'b1});
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b, expected 0", rsp_valid); end
    endtask

    task automatic test_flush();
        int acc_c, rsp_c;
        bit ok, seen;
        logic [31:0] a, b;
        do_reset();
        req_valid = 2'b01; flush = 1'b1;
        #1;
        n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL flush_idle_ready: got %b, expected 00", req_ready); end
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 2'b00;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy: got %b, expected 0", busy); end
        // kill in the first CALC cycle
        issue(1'b0, 2'd0, 32'd3, 32'd4, acc_c, ok);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        a = rand_operand(); b = rand_operand();
        req0_op = 2'd1; req1_op = 2'd3; req1_a = a; req1_b = b;
        req_valid = 2'b11;
        #1;
        n_tests++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL flush_calc_state: got %b, expected 00", {rsp_valid, busy}); end
        n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL flush_calc_rr: got %b, expected 10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(rsp_c, ok);
        n_tests++;
        if (!ok || rsp_id !== 1'b1 || rsp_data !== ref_result(2'd3, a, b)) begin
            n_fail++; $display("FAIL flush_next_rsp: got %b/%h, expected 1/%h", rsp_id, rsp_data, ref_result(2'd3, a, b));
        end
        @(posedge clk); #1;
        // kill in RESP with rsp_ready also high
        issue(1'b0, 2'd0, 32'd9, 32'd9, acc_c, ok);
        wait_rsp(rsp_c, ok);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL flush_resp_dropped: got rsp_valid/busy, expected quiet"); end
        req_valid = 2'b11;
        #1;
        n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL flush_resp_rr: got %b, expected 10", req_ready); end
        req_valid = 2'b00;
        #1;
    endtask

    task automatic test_reset_mid();
        int acc_c, rsp_c;
        bit ok, seen;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        issue(1'b0, 2'd3, 32'hDEAD_BEEF, 32'h1234_5678, acc_c, ok);
        wait_rsp(rsp_c, ok);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        m_last = 1'b1;
        #1;
        n_tests++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_state: got %b, expected 00", {rsp_valid, busy}); end
        n_tests++; if ({rsp_data, mul_x, mul_y} !== 96'd0) begin n_fail++; $display("FAIL rstmid_regs: got %h, expected 0", {rsp_data, mul_x, mul_y}); end
        req_valid = 2'b11;
        #1;
        n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_grant: got %b, expected 01", req_ready); end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL rstmid_no_rsp: got rsp_valid, expected none"); end
    endtask

    task automatic test_random(input int ncyc);
        logic [32:0] exp_q[$];
        int          acc_q[$];
        bit          prev_valid = 1'b0;
        bit          model_idle, expg;
        logic [1:0]  exp_ready, op;
        logic [31:0] a, b;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (c < ncyc - 12) begin
                req_valid = 2'($urandom_range(0, 3));
                rsp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                req_valid = 2'b00;
                rsp_ready = 1'b1;
            end
            req0_op = 2'($urandom_range(0, 3)); req0_a = rand_operand(); req0_b = rand_operand();
            req1_op = 2'($urandom_range(0, 3)); req1_a = rand_operand(); req1_b = rand_operand();
            #1;
            model_idle = (exp_q.size() == 0);
            n_tests++; if (busy !== !model_idle) begin n_fail++; $display("FAIL rand_busy: got %b, expected %b", busy, !model_idle); end
            if (rsp_valid) begin
                if (model_idle) begin
                    n_tests++; n_fail++; $display("FAIL rand_spurious_rsp: got rsp_valid, expected none");
                end else begin
                    if (!prev_valid) begin
                        n_tests++;
                        if (cyc - acc_q[0] != MUL_CYCLES) begin n_fail++; $display("FAIL rand_latency: got %0d, expected %0d", cyc - acc_q[0], MUL_CYCLES); end
                    end
                    if (rsp_ready) begin
                        n_tests++;
                        if ({rsp_id, rsp_data} !== exp_q[0]) begin n_fail++; $display("FAIL rand_rsp: got %h, expected %h", {rsp_id, rsp_data}, exp_q[0]); end
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            prev_valid = rsp_valid && !rsp_ready;
            if (req_valid != 2'b00) begin
                expg = (req_valid == 2'b11) ? !m_last : req_valid[1];
                exp_ready = !model_idle ? 2'b00 : (expg ? 2'b10 : 2'b01);
                n_tests++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready: got %b, expected %b", req_ready, exp_ready); end
                if (model_idle) begin
                    op = expg ? req1_op : req0_op;
                    a  = expg ? req1_a  : req0_a;
                    b  = expg ? req1_b  : req0_b;
                    exp_q.push_back({expg, ref_result(op, a, b)});
                    acc_q.push_back(cyc + 1);
                    m_last = expg;
                end
            end
            @(posedge clk); #1;
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d pending, expected 0", exp_q.size()); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; req_valid = 2'b00; flush = 1'b0; rsp_ready = 1'b0;
        req0_op = 2'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_op = 2'd0; req1_a = 32'd0; req1_b = 32'd0;
        m_last = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random(1500);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
